microplexer_rr_arbiter: RTL and testbench

- Round-robin arbiter sharing the 4:1 one-hot microplexer between four requesters.
- Drives the microplexer select bus (sel4, one-hot, all-zero when idle) and registers the selected input bit for downstream logic.
- Grants are held while the owner keeps requesting, up to MAX_HOLD cycles.
- Every grant change passes through one all-zero handoff cycle, so two select bits are never high together.

---
 rtl/microplexer_rr_arbiter.sv | 92 +++++++++
 tb/tb_microplexer_rr_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/microplexer_rr_arbiter.sv
// Round-robin arbiter driving the one-hot select of a 4:1 microplexer.
// Grants are held up to MAX_HOLD cycles; every owner change passes through an all-zero handoff cycle.
module microplexer_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] inputs,
    output logic [3:0] sel4,
    output logic       grant_valid,
    output logic [1:0] grant_idx,
    output logic       data_out,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ptr;
    logic             pick_valid;
    logic [1:0]       pick_idx;

    // Rotating priority search: scanning from ptr+3 down to ptr leaves the nearest requester as winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            pick_valid = pick_valid | req[ptr + 2'(k)];
            pick_idx   = req[ptr + 2'(k)] ? (ptr + 2'(k)) : pick_idx;
        end
    end

    // Arbiter state machine with registered select, owner, data and timeout outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= 2'd0;
            sel4        <= 4'b0000;
            grant_valid <= 1'b0;
            grant_idx   <= 2'd0;
            data_out    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, HANDOFF: begin
                    if (pick_valid) begin
                        state       <= GRANT;
                        cnt         <= CNT_W'(1);
                        sel4        <= 4'b0001 << pick_idx;
                        grant_valid <= 1'b1;
                        grant_idx   <= pick_idx;
                    end else begin
                        state       <= IDLE;
                        cnt         <= '0;
                        sel4        <= 4'b0000;
                        grant_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    data_out <= inputs[grant_idx];
                    // A release in the same cycle the limit is hit counts as voluntary.
                    if (!req[grant_idx] || (cnt == CNT_W'(MAX_HOLD))) begin
                        state       <= HANDOFF;
                        cnt         <= '0;
                        ptr         <= grant_idx + 2'd1;
                        sel4        <= 4'b0000;
                        grant_valid <= 1'b0;
                        timeout     <= req[grant_idx];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    sel4        <= 4'b0000;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microplexer_rr_arbiter.sv
// Self-checking bench: table-driven vectors through a scoreboard queue, then a random invariant run.
module tb_microplexer_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] inputs = 4'b0000;

    logic [3:0] sel4_a, sel4_b;
    logic       gv_a, gv_b, dout_a, dout_b, to_a, to_b;
    logic [1:0] idx_a, idx_b;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] inp;
        logic [3:0] sel;
        logic       gv;
        logic [1:0] idx;
        logic       dout;
        logic       to;
    } vec_t;

    vec_t tbl[13];
    vec_t sb[$];
    logic sb_d[$];

    microplexer_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .inputs(inputs),
        .sel4(sel4_a), .grant_valid(gv_a), .grant_idx(idx_a),
        .data_out(dout_a), .timeout(to_a)
    );

    microplexer_rr_arbiter #(.MAX_HOLD(2), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .inputs(inputs),
        .sel4(sel4_b), .grant_valid(gv_b), .grant_idx(idx_b),
        .data_out(dout_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] in,
                                input logic [3:0] s, input logic g, input logic [1:0] i,
                                input logic d, input logic t);
        vec_t v;
        v.rst_n = r; v.req = rq; v.inp = in;
        v.sel = s; v.gv = g; v.idx = i; v.dout = d; v.to = t;
        return v;
    endfunction

    // Drive one vector at the falling edge, then compare the selected DUT just after the rising edge.
    task automatic apply(input string name, input vec_t v, input bit use_b);
        vec_t       e;
        logic [3:0] s;
        logic       g, d, t;
        logic [1:0] i;
        @(negedge clk);
        rst_n  = v.rst_n;
        req    = v.req;
        inputs = v.inp;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        s = use_b ? sel4_b : sel4_a;
        g = use_b ? gv_b   : gv_a;
        i = use_b ? idx_b  : idx_a;
        d = use_b ? dout_b : dout_a;
        t = use_b ? to_b   : to_a;
        tests++;
        if (s !== e.sel || g !== e.gv || i !== e.idx || d !== e.dout || t !== e.to) begin
            fails++;
            $display("FAIL %s: got sel4=%b gv=%b idx=%0d dout=%b to=%b, expected sel4=%b gv=%b idx=%0d dout=%b to=%b",
                     name, s, g, i, d, t, e.sel, e.gv, e.idx, e.dout, e.to);
        end
    endtask

    initial begin
        logic [3:0] pat;
        logic [3:0] one;
        logic       prev_d, d;
        logic       pend;
        logic [1:0] o;

        // Reset, single requester 0, then requester 2 for three cycles, then 3 wins from ptr=3.
        tbl[0]  = mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 4'b1001, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 4'b0000, 4'b1000, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);

        for (int n = 0; n < 13; n++) apply($sformatf("table%0d", n), tbl[n], 1'b0);

        // Owner 1 releases exactly when the hold counter reaches 8: no timeout.
        apply("t4_grant", mk(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0), 1'b0);
        for (int n = 0; n < 7; n++)
            apply("t4_hold", mk(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0), 1'b0);
        apply("t4_release", mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0), 1'b0);

        // Same owner keeps requesting past 8 cycles: timeout, then sole requester re-granted.
        for (int n = 0; n < 8; n++)
            apply("maxhold_hold", mk(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0), 1'b0);
        apply("maxhold_timeout", mk(1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1), 1'b0);
        apply("maxhold_regrant", mk(1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0), 1'b0);

        // Reset mid-grant clears ptr, so 1 beats 3 afterwards.
        apply("t5_reset", mk(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0), 1'b0);
        apply("t5_after", mk(1'b1, 4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0), 1'b0);

        // All four requesting with MAX_HOLD=2: 0,1,2,3,0 each two cycles plus a timed-out handoff.
        apply("t2_reset", mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0), 1'b1);
        pat = 4'b0101;
        one = 4'b0001;
        prev_d = 1'b0;
        for (int g = 0; g < 5; g++) begin
            o = 2'(g);
            d = pat[o];
            apply($sformatf("t2_g%0d_first", g), mk(1'b1, 4'b1111, pat, one << o, 1'b1, o, prev_d, 1'b0), 1'b1);
            apply($sformatf("t2_g%0d_second", g), mk(1'b1, 4'b1111, pat, one << o, 1'b1, o, d, 1'b0), 1'b1);
            if (g < 4)
                apply($sformatf("t2_g%0d_handoff", g), mk(1'b1, 4'b1111, pat, 4'b0000, 1'b0, o, d, 1'b1), 1'b1);
            prev_d = d;
        end

        // Random traffic: select stays zero/one-hot and data_out follows inputs[grant_idx] by one cycle.
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            rst_n  = 1'b1;
            req    = 4'($urandom);
            inputs = 4'($urandom);
            pend   = gv_a;
            if (gv_a) sb_d.push_back(inputs[idx_a]);
            @(posedge clk);
            #1;
            tests++;
            if ((sel4_a & (sel4_a - 4'd1)) != 4'b0000 || ((sel4_a != 4'b0000) != gv_a) ||
                (gv_a && sel4_a != (one << idx_a))) begin
                fails++;
                $display("FAIL rand_select cycle %0d: sel4=%b gv=%b idx=%0d, required one-hot of idx iff gv",
                         n, sel4_a, gv_a, idx_a);
            end
            if (pend) begin
                d = sb_d.pop_front();
                tests++;
                if (dout_a !== d) begin
                    fails++;
                    $display("FAIL rand_data cycle %0d: data_out=%b, expected %b", n, dout_a, d);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
